// File: rtl/mipi_delay_cal.sv
// mipi_delay_cal: sweeps the deserializer delay tap and loads the centre of the widest passing eye
module mipi_delay_cal #(
    parameter int SETTLE      = 16,
    parameter int MIN_HITS    = 4,
    parameter int DEFAULT_TAP = 0
) (
    input  logic        clk,
    input  logic        resetb,
    input  logic        start,
    input  logic [15:0] win_len,
    input  logic        sync_hit,
    input  logic        lp_err,
    output logic        del_ld,
    output logic [4:0]  del_val_dat,
    output logic        busy,
    output logic        done,
    output logic        fail,
    output logic [4:0]  best_start,
    output logic [5:0]  best_len
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SETTLE, S_MEAS, S_EVAL, S_FINAL, S_DONE} state_t;
    state_t      r_state;
    logic [4:0]  r_tap;
    logic [4:0]  r_run_start;
    logic [5:0]  r_run_len;
    logic [15:0] r_win;
    logic [15:0] r_mcnt;
    logic [7:0]  r_scnt;
    logic [7:0]  r_hits;
    logic        r_err;
    logic        w_pass;
    logic        w_better;
    logic [5:0]  w_run_len;
    logic [5:0]  w_best_len;
    logic [4:0]  w_run_start;
    logic [4:0]  w_best_start;
    logic [4:0]  w_half;
    logic [4:0]  w_final;

    // verdict on the tap just measured, folded into the current run and the best run so far
    always_comb begin
        w_pass       = (r_hits >= 8'(MIN_HITS)) && !r_err;
        w_run_start  = (r_run_len == 6'd0) ? r_tap : r_run_start;
        w_run_len    = w_pass ? r_run_len + 6'd1 : 6'd0;
        w_better     = w_run_len > best_len;
        w_best_len   = w_better ? w_run_len : best_len;
        w_best_start = w_better ? w_run_start : best_start;
        w_half       = 5'((w_best_len - 6'd1) >> 1);
        w_final      = (w_best_len == 6'd0) ? 5'(DEFAULT_TAP) : w_best_start + w_half;
    end

    // sweep sequencer with registered delay-load strobe, tap value and status outputs
    always_ff @(posedge clk) begin
        if (!resetb) begin
            r_state     <= S_IDLE;
            del_ld      <= 1'b0;
            del_val_dat <= 5'(DEFAULT_TAP);
            busy        <= 1'b0;
            done        <= 1'b0;
            fail        <= 1'b0;
            best_start  <= 5'd0;
            best_len    <= 6'd0;
            r_tap       <= 5'd0;
            r_run_start <= 5'd0;
            r_run_len   <= 6'd0;
            r_win       <= 16'd1;
            r_mcnt      <= 16'd0;
            r_scnt      <= 8'd0;
            r_hits      <= 8'd0;
            r_err       <= 1'b0;
        end else begin
            del_ld <= 1'b0;
            done   <= 1'b0;
            case (r_state)
                S_IDLE: if (start) begin
                    r_state     <= S_LOAD;
                    r_tap       <= 5'd0;
                    del_ld      <= 1'b1;
                    del_val_dat <= 5'd0;
                    busy        <= 1'b1;
                    r_win       <= (win_len == 16'd0) ? 16'd1 : win_len;
                    fail        <= 1'b0;
                    best_start  <= 5'd0;
                    best_len    <= 6'd0;
                    r_run_start <= 5'd0;
                    r_run_len   <= 6'd0;
                end
                S_LOAD: begin
                    r_scnt  <= 8'd0;
                    r_state <= S_SETTLE;
                end
                S_SETTLE: begin
                    r_scnt <= r_scnt + 8'd1;
                    if (r_scnt == 8'(SETTLE - 1)) begin
                        r_state <= S_MEAS;
                        r_hits  <= 8'd0;
                        r_err   <= 1'b0;
                        r_mcnt  <= 16'd0;
                    end
                end
                S_MEAS: begin
                    if (sync_hit && r_hits != 8'hFF) r_hits <= r_hits + 8'd1;
                    if (lp_err) r_err <= 1'b1;
                    r_mcnt <= r_mcnt + 16'd1;
                    if (r_mcnt == r_win - 16'd1) r_state <= S_EVAL;
                end
                S_EVAL: begin
                    r_run_start <= w_run_start;
                    r_run_len   <= w_run_len;
                    best_start  <= w_best_start;
                    best_len    <= w_best_len;
                    del_ld      <= 1'b1;
                    if (r_tap == 5'd31) begin
                        r_state     <= S_FINAL;
                        del_val_dat <= w_final;
                        fail        <= (w_best_len == 6'd0);
                    end else begin
                        r_tap       <= r_tap + 5'd1;
                        del_val_dat <= r_tap + 5'd1;
                        r_state     <= S_LOAD;
                    end
                end
                S_FINAL: begin
                    busy    <= 1'b0;
                    done    <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mipi_delay_cal.sv
// tb_mipi_delay_cal: randomized tap sweeps scored against an eye-search reference model
`timescale 1ns/1ps
module tb_mipi_delay_cal;
    localparam int SETTLE      = 16;
    localparam int MIN_HITS    = 4;
    localparam int DEFAULT_TAP = 7;

    logic        clk = 1'b0;
    logic        resetb = 1'b0;
    logic        start = 1'b0;
    logic [15:0] win_len = 16'd0;
    logic        sync_hit = 1'b0;
    logic        lp_err = 1'b0;
    logic        del_ld;
    logic [4:0]  del_val_dat;
    logic        busy;
    logic        done;
    logic        fail;
    logic [4:0]  best_start;
    logic [5:0]  best_len;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;
    logic prev_ld = 1'b0;

    typedef struct {int cyc; int val;} ld_t;
    typedef struct {int cyc; int bs; int bl; int fin; int fl;} res_t;
    ld_t  ld_q[$];
    res_t res_q[$];

    mipi_delay_cal #(.SETTLE(SETTLE), .MIN_HITS(MIN_HITS), .DEFAULT_TAP(DEFAULT_TAP)) dut (
        .clk(clk), .resetb(resetb), .start(start), .win_len(win_len),
        .sync_hit(sync_hit), .lp_err(lp_err), .del_ld(del_ld), .del_val_dat(del_val_dat),
        .busy(busy), .done(done), .fail(fail), .best_start(best_start), .best_len(best_len)
    );

    always #5 clk = ~clk;

    // edge counter used to timestamp every delay load and done pulse
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // monitor: pops expected loads/results whenever the DUT strobes del_ld or done
    always @(negedge clk) begin
        if (resetb) begin
            if (del_ld) begin
                chk("ld_not_back_to_back", int'(prev_ld), 0);
                if (ld_q.size() == 0) chk("ld_unexpected", 1, 0);
                else begin : pop_ld
                    ld_t e;
                    e = ld_q.pop_front();
                    chk("ld_cycle", cyc, e.cyc);
                    chk("ld_tap", int'(del_val_dat), e.val);
                    chk("ld_busy", int'(busy), 1);
                end
            end
            if (done) begin
                if (res_q.size() == 0) chk("done_unexpected", 1, 0);
                else begin : pop_res
                    res_t r;
                    r = res_q.pop_front();
                    chk("done_cycle", cyc, r.cyc);
                    chk("best_start", int'(best_start), r.bs);
                    chk("best_len", int'(best_len), r.bl);
                    chk("final_tap", int'(del_val_dat), r.fin);
                    chk("fail_flag", int'(fail), r.fl);
                    chk("done_busy", int'(busy), 0);
                end
            end
        end
        prev_ld = del_ld;
    end

    function automatic logic [31:0] rng(input int a, input int b);
        logic [31:0] r;
        r = '0;
        for (int i = a; i <= b; i++) r[i] = 1'b1;
        return r;
    endfunction

    // widest eye: longest run of passing taps, earliest start on ties
    function automatic void model(input logic [31:0] ps, output int bs, output int bl, output int fin);
        bs = 0;
        bl = 0;
        for (int s = 0; s < 32; s++) begin
            int n;
            n = 0;
            while (s + n < 32 && ps[s+n]) n++;
            if (n > bl) begin
                bl = n;
                bs = s;
            end
        end
        fin = (bl == 0) ? DEFAULT_TAP : bs + (bl - 1) / 2;
    endfunction

    // mode 0: pat decides pass/fail per tap; 1: MIN_HITS-1 hits; 2: error every window; 3: activity only outside the window
    task automatic sweep(input int win, input int mode, input logic [31:0] pat, input int poke, input int rst_tap);
        int w, p, ta, bs, bl, fin, lo, m;
        int h[32];
        int off[32];
        int eoff[32];
        bit e[32];
        logic [31:0] ps;
        res_t r;
        ld_t l;
        w = (win == 0) ? 1 : win;
        p = SETTLE + w + 2;
        for (int k = 0; k < 32; k++) begin
            e[k] = 1'b0;
            lo = (MIN_HITS > w) ? w : MIN_HITS;
            case (mode)
                0: if (pat[k]) h[k] = $urandom_range(w, lo);
                   else if ($urandom_range(1, 0) == 1) h[k] = $urandom_range((MIN_HITS - 1 > w) ? w : MIN_HITS - 1, 0);
                   else begin
                       h[k] = $urandom_range(w, 0);
                       e[k] = 1'b1;
                   end
                1: h[k] = (MIN_HITS - 1 > w) ? w : MIN_HITS - 1;
                2: begin
                    h[k] = lo;
                    e[k] = 1'b1;
                end
                default: h[k] = 0;
            endcase
            off[k]  = $urandom_range(w - h[k], 0);
            eoff[k] = $urandom_range(w - 1, 0);
            ps[k]   = (h[k] >= MIN_HITS) && !e[k];
        end
        model(ps, bs, bl, fin);
        win_len = 16'(win);
        start = 1'b1;
        ta = cyc + 1;
        for (int k = 0; k < 32; k++) begin
            l.cyc = ta + k * p;
            l.val = k;
            ld_q.push_back(l);
        end
        l.cyc = ta + 32 * p;
        l.val = fin;
        ld_q.push_back(l);
        r.cyc = ta + 32 * p + 1;
        r.bs = bs;
        r.bl = bl;
        r.fin = fin;
        r.fl = (bl == 0) ? 1 : 0;
        res_q.push_back(r);
        @(posedge clk); #1;
        win_len = 16'($urandom);
        for (int k = 0; k < 32; k++) begin
            for (int c = 0; c < p; c++) begin
                m = c - SETTLE - 1;
                if (k == rst_tap && c == SETTLE + 3) begin
                    ld_q.delete();
                    res_q.delete();
                    resetb = 1'b0;
                    start = 1'b0;
                    sync_hit = 1'b0;
                    lp_err = 1'b0;
                    @(posedge clk); #1;
                    chk("rst_busy", int'(busy), 0);
                    chk("rst_tap", int'(del_val_dat), DEFAULT_TAP);
                    chk("rst_best_len", int'(best_len), 0);
                    chk("rst_best_start", int'(best_start), 0);
                    chk("rst_del_ld", int'(del_ld), 0);
                    chk("rst_fail", int'(fail), 0);
                    resetb = 1'b1;
                    return;
                end
                start = (k == poke && c == 2);
                if (m >= 0 && m < w) begin
                    sync_hit = (m >= off[k] && m < off[k] + h[k]);
                    lp_err = e[k] && (m == eoff[k]);
                end else if (mode == 3) begin
                    sync_hit = (c >= 1 && c <= SETTLE);
                    lp_err = sync_hit;
                end else begin
                    sync_hit = ($urandom_range(1, 0) == 1);
                    lp_err = ($urandom_range(7, 0) == 0);
                end
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        sync_hit = 1'b0;
        lp_err = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("all_loads_seen", ld_q.size(), 0);
        chk("done_seen", res_q.size(), 0);
    endtask

    initial begin
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("reset_del_ld", int'(del_ld), 0);
        chk("reset_tap", int'(del_val_dat), DEFAULT_TAP);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_fail", int'(fail), 0);
        chk("reset_best_start", int'(best_start), 0);
        chk("reset_best_len", int'(best_len), 0);
        resetb = 1'b1;
        @(posedge clk); #1;
        sweep(8, 0, 32'hFFFF_FFFF, -1, -1);
        sweep(8, 0, rng(10, 20), -1, -1);
        sweep(8, 0, rng(3, 6) | rng(20, 27), -1, -1);
        sweep(8, 0, rng(2, 5) | rng(10, 13), -1, -1);
        sweep(8, 1, 32'h0, -1, -1);
        sweep(8, 2, 32'h0, -1, -1);
        sweep(8, 3, 32'h0, -1, -1);
        sweep(0, 0, 32'hFFFF_FFFF, -1, -1);
        sweep(8, 0, $urandom, 5, -1);
        sweep(8, 0, 32'hFFFF_FFFF, -1, 12);
        @(posedge clk); #1;
        sweep(8, 0, $urandom, -1, -1);
        for (int i = 0; i < 2; i++) sweep($urandom_range(12, 4), 0, $urandom, -1, -1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/mipi_delay_cal.md
# mipi_delay_cal

Sweeps the data-lane input delay tap of the MIPI PHY deserializer and selects the tap at the centre of the widest passing eye. For each tap it loads the delay, waits for the line to settle, then counts sync-pattern detections and protocol errors over a measurement window. At the end it loads the centre tap of the longest contiguous run of passing taps. It runs in the PHY control clock domain and drives the deserializer's delay-load port (`del_ld` / `del_val_dat`).

## Interface

Parameters:
- `SETTLE`, 16: idle cycles after each tap load before measurement starts; legal range 1..255.
- `MIN_HITS`, 4: minimum `sync_hit` pulses in a window for the tap to pass; legal range 1..255.
- `DEFAULT_TAP`, 0: tap loaded when no tap passes; also the reset value of `del_val_dat`.

Ports:
- `clk` input 1: control clock.
- `resetb` input 1: reset, synchronous, active-low.
- `start` input 1: pulse; begins a sweep when idle.
- `win_len` input 16: measurement window in cycles; a value of 0 is treated as 1. Sampled on the accepted `start`.
- `sync_hit` input 1: one-cycle pulse per detected sync word (0xB8) from the deserializer.
- `lp_err` input 1: level; a decode/LP error is present this cycle.
- `del_ld` output 1: one-cycle delay-load strobe.
- `del_val_dat` output 5: tap value; valid and held whenever `del_ld` is high.
- `busy` output 1: a sweep is in progress.
- `done` output 1: one-cycle pulse when the final tap has been loaded.
- `fail` output 1: no tap passed in the last sweep; held until the next accepted `start`.
- `best_start` output 5: first tap of the winning run.
- `best_len` output 6: length of the winning run, 0..32.

## Operation

- States: IDLE, LOAD, SETTLE, MEAS, EVAL, FINAL, DONE.
- **IDLE:** `start` high moves to LOAD with tap = 0. On the same edge:
  - `win_len` is latched.
  - `fail`, `best_start`, `best_len`, the current-run start and the current-run length are all cleared.
- **LOAD:**
  - `del_ld` = 1 and `del_val_dat` = tap.
  - The settle counter is cleared.
  - Next state is SETTLE.
- **SETTLE:** waits `SETTLE` cycles, then moves to MEAS. On that transition the hit counter and the sticky error flag are cleared.
- **MEAS:** lasts exactly `win_len` cycles.
  - Each `sync_hit` increments the hit counter. The counter is 8 bits and saturates at 255.
  - Any `lp_err` sets the sticky error flag.
  - Inputs are ignored outside MEAS.
- **EVAL** (1 cycle): pass = (hits >= `MIN_HITS`) and no error.
  - On pass: if the current-run length is 0, the current-run start = tap; then length = length + 1. If the new length is strictly greater than `best_len`, load `best_start` and `best_len` from the current run. Earliest run wins ties.
  - On fail: current-run length = 0.
  - If tap == 31, go to FINAL; otherwise tap increments and the state returns to LOAD.
- **FINAL:** `del_ld` = 1.
  - If `best_len` > 0: `del_val_dat` = `best_start` + ((`best_len` − 1) >> 1), computed at 5-bit width. The result is at most 31, so no wrap occurs.
  - If `best_len` == 0: `del_val_dat` = `DEFAULT_TAP` and `fail` = 1.
- **DONE:** `done` = 1 for one cycle, then IDLE. `del_val_dat` holds the final value.
- `start` is ignored outside IDLE.
- Reset mid-sweep returns to IDLE with every output at its reset value; the partial sweep is discarded.

## Timing

- Reset values:
  - `del_ld` = 0, `del_val_dat` = `DEFAULT_TAP`.
  - `busy` = 0, `done` = 0, `fail` = 0.
  - `best_start` = 0, `best_len` = 0.
- If `start` is accepted at edge t, tap k's LOAD cycle (`del_ld` high) is cycle t + 1 + k·P, where P = `SETTLE` + W + 2 and W = max(`win_len`, 1).
- FINAL (the last `del_ld`) is cycle t + 1 + 32·P. `done` is high the cycle after FINAL.
- `busy` is high from cycle t + 1 through FINAL inclusive, and low in the DONE cycle.
- `best_start`, `best_len` and `fail` are valid when `done` is high, and hold until the next accepted `start`.
- `del_ld` is asserted exactly 33 times per completed sweep and never in two consecutive cycles.

## Test plan

- **All taps pass:** `MIN_HITS` hits per window, no `lp_err` → `best_start` = 0, `best_len` = 32, final `del_val_dat` = 15, `fail` = 0.
- **Single eye:** only taps 10..20 pass → `best_start` = 10, `best_len` = 11, final tap 15. Two eyes 3..6 and 20..27 → `best_start` = 20, `best_len` = 8, final tap 23.
- **Tie:** runs 2..5 and 10..13 → `best_start` = 2, `best_len` = 4, final tap 3.
- **No pass:** hits = `MIN_HITS` − 1 on every tap, or an `lp_err` pulse in every window → `fail` = 1, `best_len` = 0, final tap = `DEFAULT_TAP`. In a separate case, `sync_hit`/`lp_err` driven only during SETTLE are ignored, so every tap fails.
- **Cycle count:** with `SETTLE` = 16 and `win_len` = 8 (P = 26), `del_ld` pulses occur at t+1, t+27, …, t+833; `done` is at t+834. With `win_len` = 0 the spacing becomes 19.
- **Control edge cases:**
  - `start` pulsed while `busy` → no restart; pulse positions are unchanged.
  - `resetb` low during the tap-12 MEAS → next cycle `busy` = 0, `del_val_dat` = `DEFAULT_TAP`, `best_len` = 0; a fresh `start` sweeps from tap 0.
